writeback_branch: RTL and testbench
===================================

# writeback_branch

Consumer of the execute-stage result bundle. Each cycle it takes the ALU result, register-file write controls, status-register write enable and branch request from the final execute stage. It maintains the N/Z/C/V status register, resolves conditional branches against it, and issues a one-cycle PC redirect. It then squashes the in-flight instructions behind a taken branch for a fixed window and drives the register-file write port.

## Interface
Parameters:
- FLUSH_DEPTH, 8: cycles squashed after a taken branch (the fetch-to-writeback depth); legal range 1..15.

Ports (widths from the shared `defines.v` macros):
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- p_i  in  48  ALU result.
- regfile_we_w_i  in  1  full-word write request.
- regfile_we_uhw_i  in  1  upper-halfword write request.
- regfile_addr_i  in  `reg_addr_width  destination register.
- branchen_i  in  1  instruction is a branch.
- condcode_i  in  `cond_code_width  branch condition (4 bits).
- branchtrgt_i  in  `im_addr_width  branch target.
- sr_we_i  in  1  instruction updates flags.
- rf_we_w_o  out  1  registered full-word write enable.
- rf_we_uhw_o  out  1  registered upper-halfword write enable.
- rf_addr_o  out  `reg_addr_width  registered write address.
- rf_data_o  out  `datawidth  registered write data, equal to p_i[`datawidth-1:0].
- sr_o  out  4  status register {N,Z,C,V}.
- pc_redirect_o  out  1  one-cycle pulse: take the branch.
- pc_target_o  out  `im_addr_width  redirect address, valid while pc_redirect_o is high.
- flushing_o  out  1  high while the squash window is active.

## Operation
- Flags computed from p_i: N=p_i[31]; Z=(p_i[31:0]==0); C=p_i[32]; V=p_i[32]^p_i[31].
- Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- A branch is taken when all of these hold: branchen_i=1, the condition is true against sr_o, and state is IDLE.
- FSM has two states:
  - IDLE to FLUSH on a taken branch; the counter loads FLUSH_DEPTH-1.
  - In FLUSH the counter decrements each cycle; the FSM returns to IDLE when it reads 0 and decrements.
- In FLUSH, every input instruction is squashed:
  - rf_we_w_o and rf_we_uhw_o are 0.
  - sr_we_i is ignored.
  - branchen_i is ignored.
- The taken branch itself still commits its own register write and flag update.
- In IDLE, the write controls pass through one register stage. When sr_we_i=1, sr_o loads the new flags; otherwise it holds.
- Both write enables may be high together; they are passed through unchanged and the register file decides.

## Timing
- Reset values: all outputs 0, sr_o=4'b0000, state IDLE, counter 0. Reset mid-flush returns the block to IDLE on the next edge.
- Latency is one cycle from inputs at edge t to rf_*_o, sr_o, pc_redirect_o and pc_target_o after edge t.
- pc_redirect_o is high for exactly one cycle per taken branch.
- flushing_o is high for exactly FLUSH_DEPTH cycles, starting the same cycle as pc_redirect_o.
- Back-to-back: an instruction arriving the cycle after the flush window ends is live and may branch again.
- Flag-setting instruction at cycle t, branch at t+1: the branch sees the new flags (sr_o is updated at t+1).

## Configuration
- WB_SR_BYPASS_EN defined: when a single instruction has sr_we_i=1 and branchen_i=1 together (compare-and-branch), the condition is evaluated against the flags computed from the current p_i.
- WB_SR_BYPASS_EN undefined: the condition is always evaluated against registered sr_o, so such a branch sees the previous flags.

## Structure
- The condition-code encodings and the flag bit positions (N=3, Z=2, C=1, V=0) go in the shared `defines.v`.
- One natural sub-module, cond_eval: a combinational function of the 4-bit condition and the 4-bit flags that returns the taken bit.

## Test plan
- Reset: hold rst=1 for 2 cycles with random inputs -> all outputs 0 and sr_o=0.
- Flag update: p_i=48'h0_0000_0000 with sr_we_i=1 -> next cycle sr_o=4'b0100. Then p_i=48'h1_8000_0000 with sr_we_i=1 -> sr_o=4'b1010.
- Conditional branch:
  - With sr_o Z=1, branch EQ to target 0x40 -> pc_redirect_o pulses with pc_target_o=0x40.
  - The same branch with NE -> no pulse; with NV -> no pulse.
- Squash window with FLUSH_DEPTH=8: taken branch, then 8 cycles of regfile_we_w_i=1, sr_we_i=1 and branchen_i=1 AL.
  - Required: flushing_o high for 8 cycles, no writes, sr_o unchanged, no second redirect.
  - The 9th instruction writes normally.
- Bypass: sr_o=0 and a single instruction with p_i=0, sr_we_i=1, branchen_i=1, EQ.
  - With WB_SR_BYPASS_EN the branch is taken; without it, it is not taken.
- Reset mid-flush: assert rst at flush cycle 3 -> flushing_o=0 the next cycle, and the following AL branch is taken.

Source files
------------

// File: rtl/writeback_branch_pkg.sv
// Shared widths, flag positions and condition codes for writeback_branch.
// Also provides the flag-extraction helper used by the writeback stage.
package writeback_branch_pkg;

    localparam int P_WIDTH         = 48;
    localparam int DATAWIDTH       = 32;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int IM_ADDR_WIDTH   = 16;
    localparam int COND_CODE_WIDTH = 4;
    localparam int CNT_W           = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [COND_CODE_WIDTH-1:0] {
        CC_EQ = 4'h0,
        CC_NE = 4'h1,
        CC_CS = 4'h2,
        CC_CC = 4'h3,
        CC_MI = 4'h4,
        CC_PL = 4'h5,
        CC_VS = 4'h6,
        CC_VC = 4'h7,
        CC_HI = 4'h8,
        CC_LS = 4'h9,
        CC_GE = 4'hA,
        CC_LT = 4'hB,
        CC_GT = 4'hC,
        CC_LE = 4'hD,
        CC_AL = 4'hE,
        CC_NV = 4'hF
    } cond_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } wb_state_e;

    // {N,Z,C,V} from an ALU result; bit 32 is the carry-out.
    function automatic logic [3:0] flags_of(input logic [32:0] p);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = p[31];
        f[FLAG_Z] = (p[31:0] == 32'd0);
        f[FLAG_C] = p[32];
        f[FLAG_V] = p[32] ^ p[31];
        return f;
    endfunction

endpackage

// File: rtl/writeback_branch_if.sv
// Execute-to-writeback bundle plus the writeback outputs.
// master: execute side / bench; slave: writeback_branch.
interface writeback_branch_if;
    import writeback_branch_pkg::*;

    logic [P_WIDTH-1:0]         p_i;
    logic                       regfile_we_w_i;
    logic                       regfile_we_uhw_i;
    logic [REG_ADDR_WIDTH-1:0]  regfile_addr_i;
    logic                       branchen_i;
    logic [COND_CODE_WIDTH-1:0] condcode_i;
    logic [IM_ADDR_WIDTH-1:0]   branchtrgt_i;
    logic                       sr_we_i;

    logic                       rf_we_w_o;
    logic                       rf_we_uhw_o;
    logic [REG_ADDR_WIDTH-1:0]  rf_addr_o;
    logic [DATAWIDTH-1:0]       rf_data_o;
    logic [3:0]                 sr_o;
    logic                       pc_redirect_o;
    logic [IM_ADDR_WIDTH-1:0]   pc_target_o;
    logic                       flushing_o;

    modport master (
        output p_i, regfile_we_w_i, regfile_we_uhw_i, regfile_addr_i,
        output branchen_i, condcode_i, branchtrgt_i, sr_we_i,
        input  rf_we_w_o, rf_we_uhw_o, rf_addr_o, rf_data_o,
        input  sr_o, pc_redirect_o, pc_target_o, flushing_o
    );

    modport slave (
        input  p_i, regfile_we_w_i, regfile_we_uhw_i, regfile_addr_i,
        input  branchen_i, condcode_i, branchtrgt_i, sr_we_i,
        output rf_we_w_o, rf_we_uhw_o, rf_addr_o, rf_data_o,
        output sr_o, pc_redirect_o, pc_target_o, flushing_o
    );

endinterface

// File: rtl/writeback_branch_cond_eval.sv
// Combinational branch-condition evaluator.
// Ports: cond (4-bit code), flags ({N,Z,C,V}) in; taken out.
module writeback_branch_cond_eval
    import writeback_branch_pkg::*;
(
    input  logic [COND_CODE_WIDTH-1:0] cond,
    input  logic [3:0]                 flags,
    output logic                       taken
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        unique case (cond_e'(cond))
            CC_EQ: taken = z;
            CC_NE: taken = !z;
            CC_CS: taken = c;
            CC_CC: taken = !c;
            CC_MI: taken = n;
            CC_PL: taken = !n;
            CC_VS: taken = v;
            CC_VC: taken = !v;
            CC_HI: taken = c && !z;
            CC_LS: taken = !c || z;
            CC_GE: taken = (n == v);
            CC_LT: taken = (n != v);
            CC_GT: taken = !z && (n == v);
            CC_LE: taken = z || (n != v);
            CC_AL: taken = 1'b1;
            CC_NV: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/writeback_branch.sv
// Writeback stage: flag register, branch resolve/redirect, squash window.
// Ports: clk, rst (sync, active-high), bus (writeback_branch_if.slave).
// Option WB_SR_BYPASS_EN: compare-and-branch sees its own new flags.
module writeback_branch
    import writeback_branch_pkg::*;
#(
    parameter int FLUSH_DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    writeback_branch_if.slave bus
);

    wb_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     we_w_q;
    logic                     we_uhw_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0]     data_q;
    logic [3:0]               sr_q;
    logic                     redirect_q;
    logic [IM_ADDR_WIDTH-1:0] target_q;

    logic [3:0]               new_flags;
    logic [3:0]               cond_flags;
    logic                     cond_true;
    logic                     live;
    logic                     take;
    logic                     unused_p_hi;

    assign new_flags   = flags_of(bus.p_i[32:0]);
    assign unused_p_hi = ^bus.p_i[P_WIDTH-1:33];

`ifdef WB_SR_BYPASS_EN
    assign cond_flags = (bus.sr_we_i && bus.branchen_i) ? new_flags : sr_q;
`else
    assign cond_flags = sr_q;
`endif

    writeback_branch_cond_eval u_cond_eval (
        .cond  (bus.condcode_i),
        .flags (cond_flags),
        .taken (cond_true)
    );

    // Anything arriving while the window is open is a wrong-path op.
    assign live = (state_q == S_IDLE);
    assign take = live && bus.branchen_i && cond_true;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (take) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
                end
            end
            (state_q == S_FLUSH): begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_w_q     <= 1'b0;
            we_uhw_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sr_q       <= '0;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            we_w_q     <= live && bus.regfile_we_w_i;
            we_uhw_q   <= live && bus.regfile_we_uhw_i;
            addr_q     <= bus.regfile_addr_i;
            data_q     <= bus.p_i[DATAWIDTH-1:0];
            redirect_q <= take;
            target_q   <= take ? bus.branchtrgt_i : '0;
            if (live && bus.sr_we_i) begin
                sr_q <= new_flags;
            end
        end
    end

    assign bus.rf_we_w_o     = we_w_q;
    assign bus.rf_we_uhw_o   = we_uhw_q;
    assign bus.rf_addr_o     = addr_q;
    assign bus.rf_data_o     = data_q;
    assign bus.sr_o          = sr_q;
    assign bus.pc_redirect_o = redirect_q;
    assign bus.pc_target_o   = target_q;
    assign bus.flushing_o    = (state_q == S_FLUSH);

endmodule

// File: tb/tb_writeback_branch.sv
// Self-checking bench for writeback_branch: directed table, hand
// sequences for reset/flush corners, and random vs. a reference model.
module tb_writeback_branch;

    localparam int D = 8;

`ifdef WB_SR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    writeback_branch_if bus ();

    writeback_branch #(.FLUSH_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic drive(input logic [47:0] p, input logic we_w,
                         input logic uhw, input logic [4:0] addr,
                         input logic br, input logic [3:0] cc,
                         input logic [15:0] trgt, input logic sr_we);
        bus.p_i              = p;
        bus.regfile_we_w_i   = we_w;
        bus.regfile_we_uhw_i = uhw;
        bus.regfile_addr_i   = addr;
        bus.branchen_i       = br;
        bus.condcode_i       = cc;
        bus.branchtrgt_i     = trgt;
        bus.sr_we_i          = sr_we;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive('0, 1'b0, 1'b0, '0, 1'b0, 4'h0, '0, 1'b0);
    endtask

    // Reference model: flags and condition table written from the rules.
    function automatic logic [3:0] ref_flags(input logic [47:0] p);
        logic n, z, c, v;
        n = p[31];
        z = (p[31:0] == 32'd0);
        c = p[32];
        v = p[32] ^ p[31];
        return {n, z, c, v};
    endfunction

    function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [47:0] p;
        logic        we_w;
        logic [4:0]  addr;
        logic        br;
        logic [3:0]  cc;
        logic [15:0] trgt;
        logic        sr_we;
        logic [3:0]  e_sr;
        logic        e_redir;
        logic        e_flush;
        logic        e_we;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic [47:0] p, input logic we_w, input logic [4:0] addr,
        input logic br, input logic [3:0] cc, input logic [15:0] trgt,
        input logic sr_we, input logic [3:0] e_sr, input logic e_redir,
        input logic e_flush, input logic e_we);
        vec_t r;
        r.p = p; r.we_w = we_w; r.addr = addr; r.br = br; r.cc = cc;
        r.trgt = trgt; r.sr_we = sr_we; r.e_sr = e_sr;
        r.e_redir = e_redir; r.e_flush = e_flush; r.e_we = e_we;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_rem;
        logic [3:0] m_sr;
        int flen;

        // Reset with random inputs on the bus.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive({$urandom, $urandom}, 1'($urandom), 1'($urandom),
                  5'($urandom), 1'($urandom), 4'($urandom),
                  16'($urandom), 1'($urandom));
            tick();
        end
        chk("rst_we_w", bus.rf_we_w_o, 0);
        chk("rst_we_uhw", bus.rf_we_uhw_o, 0);
        chk("rst_addr", bus.rf_addr_o, 0);
        chk("rst_data", bus.rf_data_o, 0);
        chk("rst_sr", bus.sr_o, 0);
        chk("rst_redir", bus.pc_redirect_o, 0);
        chk("rst_target", bus.pc_target_o, 0);
        chk("rst_flush", bus.flushing_o, 0);
        rst = 1'b0;

        // Directed table.
        vt.push_back(mk(48'h0, 1, 5'd1, 0, 4'h0, 16'h0, 1, 4'b0100, 0, 0, 1));
        vt.push_back(mk(48'h1_8000_0000, 0, 5'd2, 0, 4'h0, 16'h0, 1,
                        4'b1010, 0, 0, 0));
        vt.push_back(mk(48'h0, 0, 5'd0, 0, 4'h0, 16'h0, 1, 4'b0100, 0, 0, 0));
        vt.push_back(mk(48'h1234, 1, 5'd3, 1, 4'h0, 16'h40, 0,
                        4'b0100, 1, 1, 1));
        for (int k = 1; k <= D; k++)
            vt.push_back(mk(48'h1_8000_0000, 1, 5'd5, 1, 4'hE, 16'h99, 1,
                            4'b0100, 0, (k < D), 0));
        vt.push_back(mk(48'h1_8000_0000, 1, 5'd7, 0, 4'h0, 16'h0, 1,
                        4'b1010, 0, 0, 1));
        vt.push_back(mk(48'h0, 0, 5'd0, 0, 4'h0, 16'h0, 1, 4'b0100, 0, 0, 0));
        vt.push_back(mk(48'h0, 0, 5'd0, 1, 4'h1, 16'h40, 0, 4'b0100, 0, 0, 0));
        vt.push_back(mk(48'h0, 0, 5'd0, 1, 4'hF, 16'h40, 0, 4'b0100, 0, 0, 0));
        vt.push_back(mk(48'h1, 0, 5'd0, 0, 4'h0, 16'h0, 1, 4'b0000, 0, 0, 0));
        vt.push_back(mk(48'h0, 0, 5'd0, 1, 4'h0, 16'h80, 1,
                        4'b0100, BYP, BYP, 0));

        foreach (vt[i]) begin
            drive(vt[i].p, vt[i].we_w, 1'b0, vt[i].addr, vt[i].br,
                  vt[i].cc, vt[i].trgt, vt[i].sr_we);
            tick();
            chk($sformatf("v%0d_sr", i), bus.sr_o, vt[i].e_sr);
            chk($sformatf("v%0d_redir", i), bus.pc_redirect_o, vt[i].e_redir);
            chk($sformatf("v%0d_flush", i), bus.flushing_o, vt[i].e_flush);
            chk($sformatf("v%0d_we", i), bus.rf_we_w_o, vt[i].e_we);
            if (vt[i].e_redir)
                chk($sformatf("v%0d_tgt", i), bus.pc_target_o, vt[i].trgt);
            if (vt[i].e_we) begin
                chk($sformatf("v%0d_addr", i), bus.rf_addr_o, vt[i].addr);
                chk($sformatf("v%0d_data", i), bus.rf_data_o,
                    {32'h0, vt[i].p[31:0]});
            end
        end

        // Drain any open window.
        idle();
        for (int i = 0; i < D + 2; i++) tick();

        // Reset in the third flush cycle.
        drive(48'h0, 0, 0, 5'd0, 1, 4'hE, 16'h20, 0);
        tick();
        chk("mf_redir", bus.pc_redirect_o, 1);
        chk("mf_flush1", bus.flushing_o, 1);
        tick();
        tick();
        chk("mf_flush3", bus.flushing_o, 1);
        chk("mf_no_redir", bus.pc_redirect_o, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mf_rst_flush", bus.flushing_o, 0);
        chk("mf_rst_sr", bus.sr_o, 0);
        drive(48'h0, 0, 0, 5'd0, 1, 4'hE, 16'h24, 0);
        tick();
        chk("mf_al_redir", bus.pc_redirect_o, 1);
        chk("mf_al_tgt", bus.pc_target_o, 16'h24);

        // Window length, with further branches offered throughout.
        drive(48'h0, 1, 0, 5'd1, 1, 4'hE, 16'h30, 1);
        flen = 1;
        for (int g = 0; g < 30 && bus.flushing_o; g++) begin
            tick();
            if (bus.pc_redirect_o) chk("win_redir", bus.pc_redirect_o, 0);
            if (bus.flushing_o) flen++;
        end
        chk("win_len", flen, D);
        chk("win_after_redir", bus.pc_redirect_o, 0);

        // Random phase against the reference model.
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        m_rem = 0;
        m_sr  = '0;
        for (int i = 0; i < 600; i++) begin
            logic [47:0] p;
            logic we_w, uhw, br, sr_we, r, live, tk;
            logic [4:0] addr;
            logic [3:0] cc, nf, cf;
            logic [15:0] trgt;
            logic e_we, e_uhw;

            p = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) p[31:0] = '0;
            we_w  = 1'($urandom);
            uhw   = 1'($urandom);
            addr  = 5'($urandom);
            br    = ($urandom_range(0, 3) == 0);
            cc    = 4'($urandom);
            trgt  = 16'($urandom);
            sr_we = 1'($urandom);
            r     = ($urandom_range(0, 99) == 0);
            rst   = r;
            drive(p, we_w, uhw, addr, br, cc, trgt, sr_we);

            if (r) begin
                m_rem = 0;
                m_sr  = '0;
                e_we  = 0;
                e_uhw = 0;
                tk    = 0;
            end else begin
                live = (m_rem == 0);
                nf   = ref_flags(p);
                cf   = (BYP && sr_we && br) ? nf : m_sr;
                tk   = live && br && ref_cond(cc, cf);
                e_we  = live && we_w;
                e_uhw = live && uhw;
                if (live && sr_we) m_sr = nf;
                if (tk) m_rem = D;
                else if (m_rem > 0) m_rem--;
            end

            tick();
            chk($sformatf("r%0d_we", i), bus.rf_we_w_o, e_we);
            chk($sformatf("r%0d_uhw", i), bus.rf_we_uhw_o, e_uhw);
            chk($sformatf("r%0d_sr", i), bus.sr_o, m_sr);
            chk($sformatf("r%0d_redir", i), bus.pc_redirect_o, tk);
            chk($sformatf("r%0d_flush", i), bus.flushing_o, m_rem > 0);
            if (tk) chk($sformatf("r%0d_tgt", i), bus.pc_target_o, trgt);
            if (e_we || e_uhw) begin
                chk($sformatf("r%0d_addr", i), bus.rf_addr_o, addr);
                chk($sformatf("r%0d_data", i), bus.rf_data_o, {32'h0, p[31:0]});
            end
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
